// File: rtl/name_char_uart_tx.sv
// name_char_uart_tx: buffers 7-bit ASCII characters from the one-hot-ring coder
// in a small FIFO and sends each one as a UART-style frame on TXD.
// Frame: start (0), 7 data bits LSB first, optional even parity, stop (1).
// Every bit lasts DIV clocks. Back-to-back frames have no idle gap.
module name_char_uart_tx #(
    parameter int DEPTH     = 4,  // FIFO entries, power of two, >= 2
    parameter int DIV       = 4,  // clocks per serial bit period, >= 1
    parameter int PARITY_EN = 1   // 1 = append even-parity bit
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [0:6]                     C,
    input  logic                           C_VALID,
    output logic                           C_READY,
    output logic                           TXD,
    output logic                           BUSY,
    output logic [$clog2(DEPTH+1)-1:0]     COUNT,
    output logic                           OVF
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   div_reg, div_next;
    logic [2:0]      bit_reg, bit_next;
    logic [6:0]      shift_reg, shift_next;
    logic            par_reg, par_next;
    logic            txd_reg, txd_next;

    logic [CW-1:0]   count_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic            ovf_reg;
    logic [6:0]      mem [DEPTH];

    logic [6:0]      c_lsb;     // character re-indexed so bit 0 is the ASCII LSB
    logic [6:0]      head;
    logic            full;
    logic            push;
    logic            pop;
    logic            div_last;

    // The coder numbers C MSB-first; flip it so shifting right sends LSB first.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_bit_rev
            assign c_lsb[gi] = C[6 - gi];
        end
    endgenerate

    assign full     = (count_reg == CW'(DEPTH));
    assign push     = C_VALID && !full;
    assign div_last = (div_reg == DW'(DIV - 1));
    assign head     = mem[rd_ptr_reg];

    // FIFO storage write; contents need no reset because COUNT gates every read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= c_lsb;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (C_VALID && full) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // Serialiser state register; TXD is registered so it only moves on rollover edges.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= S_IDLE;
            div_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            par_reg   <= 1'b0;
            txd_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            par_reg   <= par_next;
            txd_reg   <= txd_next;
        end
    end

    // Next-state logic: bit sequencing and the FIFO pop decision.
    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        par_next   = par_reg;
        txd_next   = txd_reg;
        pop        = 1'b0;

        if (state_reg != S_IDLE) begin
            div_next = div_last ? '0 : div_reg + DW'(1);
        end

        case (state_reg)
            S_IDLE: begin
                if (count_reg != '0) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (div_last) begin
                    state_next = S_DATA;
                    bit_next   = '0;
                    txd_next   = shift_reg[0];
                    shift_next = {1'b0, shift_reg[6:1]};
                end
            end
            S_DATA: begin
                if (div_last) begin
                    if (bit_reg == 3'd6) begin
                        if (PARITY_EN != 0) begin
                            state_next = S_PARITY;
                            txd_next   = par_reg;
                        end else begin
                            state_next = S_STOP;
                            txd_next   = 1'b1;
                        end
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        txd_next   = shift_reg[0];
                        shift_next = {1'b0, shift_reg[6:1]};
                    end
                end
            end
            S_PARITY: begin
                if (div_last) begin
                    state_next = S_STOP;
                    txd_next   = 1'b1;
                end
            end
            S_STOP: begin
                if (div_last) begin
                    if (count_reg != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                txd_next   = 1'b1;
            end
        endcase

        // A pop starts the next frame: start bit goes out on this same edge.
        if (pop) begin
            state_next = S_START;
            div_next   = '0;
            bit_next   = '0;
            shift_next = head;
            par_next   = ^head;
            txd_next   = 1'b0;
        end
    end

    assign C_READY = !full;
    assign TXD     = txd_reg;
    assign BUSY    = (state_reg != S_IDLE) || (count_reg != '0);
    assign COUNT   = count_reg;
    assign OVF     = ovf_reg;

endmodule

// File: tb/tb_name_char_uart_tx.sv
// Testbench for name_char_uart_tx: table of single-character frames on three
// parameterisations, plus hand-written sequences for FIFO fill/overflow,
// asynchronous reset mid-frame and continuous DIV=1 streaming.
module tb_name_char_uart_tx;

    logic             CLK;
    logic             RST_N;
    logic [0:6]       c;
    logic [2:0]       v;
    logic [2:0]       rdy_w;
    logic [2:0]       txd_w;
    logic [2:0]       busy_w;
    logic [2:0]       ovf_w;
    logic [2:0][2:0]  cnt_w;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // dut0: DIV=4 with parity, dut1: DIV=4 without parity, dut2: DIV=1 with parity
    name_char_uart_tx #(.DEPTH(4), .DIV(4), .PARITY_EN(1)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .C(c), .C_VALID(v[0]), .C_READY(rdy_w[0]),
        .TXD(txd_w[0]), .BUSY(busy_w[0]), .COUNT(cnt_w[0]), .OVF(ovf_w[0]));
    name_char_uart_tx #(.DEPTH(4), .DIV(4), .PARITY_EN(0)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .C(c), .C_VALID(v[1]), .C_READY(rdy_w[1]),
        .TXD(txd_w[1]), .BUSY(busy_w[1]), .COUNT(cnt_w[1]), .OVF(ovf_w[1]));
    name_char_uart_tx #(.DEPTH(4), .DIV(1), .PARITY_EN(1)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .C(c), .C_VALID(v[2]), .C_READY(rdy_w[2]),
        .TXD(txd_w[2]), .BUSY(busy_w[2]), .COUNT(cnt_w[2]), .OVF(ovf_w[2]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Edge counter: read #1 after an edge it equals the index of that edge.
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [6:0] ch;    // ASCII code
        int         sel;   // which DUT
        logic [6:0] seq;   // data bits in line order, leftmost sent first
        logic       par;   // expected even-parity bit
    } vec_t;

    vec_t       tab [6];
    logic [6:0] pk      [6];
    logic [6:0] pk_seq  [6];
    logic       pk_par  [6];
    int         pk_cnt  [6];

    function automatic int div_of(input int sel);
        return (sel == 2) ? 1 : 4;
    endfunction

    function automatic bit pen_of(input int sel);
        return (sel == 1) ? 1'b0 : 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Check each bit period of a frame that started at edge 'start'; samples
    // already in the past are skipped.
    task automatic check_frame(input string nm, input int sel, input logic [6:0] seq,
                               input logic par, input int start);
        int   div;
        int   nb;
        int   tgt;
        bit   pen;
        bit   bad;
        logic e;
        logic act;
        div = div_of(sel);
        pen = pen_of(sel);
        nb  = pen ? 10 : 9;
        for (int b = 0; b < nb; b++) begin
            if (b == 0)                 e = 1'b0;
            else if (b <= 7)            e = seq[7 - b];
            else if (pen && b == 8)     e = par;
            else                        e = 1'b1;
            bad = 1'b0;
            act = e;
            for (int s = 0; s < div; s++) begin
                tgt = start + b * div + s;
                if (tgt >= cyc) begin
                    while (cyc < tgt) begin
                        @(posedge CLK); #1;
                    end
                    if (txd_w[sel] !== e) begin
                        bad = 1'b1;
                        act = txd_w[sel];
                    end
                end
            end
            tests++;
            if (bad) begin
                fails++;
                $display("FAIL %s bit%0d: TXD=%b, required %b for the whole bit period", nm, b, act, e);
            end
        end
    endtask

    // Wait (bounded) for a start bit, then check the full frame.
    task automatic run_frame(input string nm, input int sel, input logic [6:0] seq,
                             input logic par, output int start);
        int to;
        to = 0;
        do begin
            @(posedge CLK); #1;
            to++;
        end while (txd_w[sel] !== 1'b0 && to < 100);
        start = cyc;
        chk({nm, " start bit seen"}, txd_w[sel], 1'b0);
        check_frame(nm, sel, seq, par, start);
        $display("[TB] frame %s on dut%0d started at edge %0d", nm, sel, start);
    endtask

    // Push "Peklar" into dut0 on six consecutive edges; returns the edge where P starts.
    task automatic push_peklar(input string nm, output int sp);
        sp = 0;
        for (int i = 0; i < 6; i++) begin
            c    = pk[i];
            v[0] = 1'b1;
            @(posedge CLK); #1;
            chk($sformatf("%s count after push %0d", nm, i), cnt_w[0], pk_cnt[i]);
            if (i == 1) begin
                sp = cyc;
                chk($sformatf("%s P start bit on second edge", nm), txd_w[0], 1'b0);
            end
        end
        v[0] = 1'b0;
        chk({nm, " ovf after r"}, ovf_w[0], 1'b1);
        chk({nm, " ready after r"}, rdy_w[0], 1'b0);
        $display("[TB] %s pushed, P started at edge %0d", nm, sp);
    endtask

    initial begin
        int   acc;
        int   st;
        int   sp;
        int   a;
        int   k;
        int   j;
        bit   cbad;
        bit   hbad;
        bit   fbad [4];
        logic e;

        tab[0] = '{7'h50, 0, 7'b0000101, 1'b0};  // 'P'
        tab[1] = '{7'h6B, 0, 7'b1101011, 1'b1};  // 'k'
        tab[2] = '{7'h6B, 1, 7'b1101011, 1'b0};  // 'k' without parity
        tab[3] = '{7'h61, 2, 7'b1000011, 1'b1};  // 'a' DIV=1
        tab[4] = '{7'h65, 0, 7'b1010011, 1'b0};  // 'e'
        tab[5] = '{7'h6C, 1, 7'b0011011, 1'b0};  // 'l' without parity

        pk[0] = 7'h50; pk_seq[0] = 7'b0000101; pk_par[0] = 1'b0; pk_cnt[0] = 1;
        pk[1] = 7'h65; pk_seq[1] = 7'b1010011; pk_par[1] = 1'b0; pk_cnt[1] = 1;
        pk[2] = 7'h6B; pk_seq[2] = 7'b1101011; pk_par[2] = 1'b1; pk_cnt[2] = 2;
        pk[3] = 7'h6C; pk_seq[3] = 7'b0011011; pk_par[3] = 1'b0; pk_cnt[3] = 3;
        pk[4] = 7'h61; pk_seq[4] = 7'b1000011; pk_par[4] = 1'b1; pk_cnt[4] = 4;
        pk[5] = 7'h72; pk_seq[5] = 7'b0100111; pk_par[5] = 1'b0; pk_cnt[5] = 4;

        RST_N = 1'b1;
        c     = '0;
        v     = '0;

        // Reset takes effect with no clock edge
        #2 RST_N = 1'b0;
        #1;
        chk("reset TXD", txd_w[0], 1'b1);
        chk("reset C_READY", rdy_w[0], 1'b1);
        chk("reset BUSY", busy_w[0], 1'b0);
        chk("reset COUNT", cnt_w[0], 0);
        chk("reset OVF", ovf_w[0], 1'b0);
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;

        // Single-character frames from the table
        for (int i = 0; i < 6; i++) begin
            c = tab[i].ch;
            v[tab[i].sel] = 1'b1;
            @(posedge CLK); #1;
            acc = cyc;
            v   = '0;
            chk($sformatf("v%0d count after push", i), cnt_w[tab[i].sel], 1);
            chk($sformatf("v%0d no bypass", i), txd_w[tab[i].sel], 1'b1);
            run_frame($sformatf("v%0d", i), tab[i].sel, tab[i].seq, tab[i].par, st);
            chk($sformatf("v%0d start latency", i), st - acc, 1);
            chk($sformatf("v%0d busy in stop", i), busy_w[tab[i].sel], 1'b1);
            @(posedge CLK); #1;
            chk($sformatf("v%0d busy after frame", i), busy_w[tab[i].sel], 1'b0);
            chk($sformatf("v%0d idle line", i), txd_w[tab[i].sel], 1'b1);
        end

        // "Peklar" burst: fill, overflow, back-to-back frames
        push_peklar("burst", sp);
        check_frame("burst P", 0, pk_seq[0], pk_par[0], sp);
        chk("burst ready before first pop", rdy_w[0], 1'b0);
        chk("burst count before first pop", cnt_w[0], 4);
        for (int i = 1; i < 5; i++) begin
            run_frame($sformatf("burst %0d", i), 0, pk_seq[i], pk_par[i], st);
            chk($sformatf("burst %0d no gap", i), st - sp, 40 * i);
            if (i == 1) begin
                chk("burst ready after pop", rdy_w[0], 1'b1);
                chk("burst count after pop", cnt_w[0], 3);
            end
        end
        @(posedge CLK); #1;
        chk("burst busy after 50 bits", busy_w[0], 1'b0);
        chk("burst ovf sticky", ovf_w[0], 1'b1);
        chk("burst count empty", cnt_w[0], 0);

        // Asynchronous reset in the middle of the second frame's data
        push_peklar("rst", sp);
        check_frame("rst P", 0, pk_seq[0], pk_par[0], sp);
        while (cyc < sp + 49) begin
            @(posedge CLK); #1;
        end
        chk("rst pre TXD data bit", txd_w[0], 1'b0);
        chk("rst pre count", cnt_w[0], 3);
        #1 RST_N = 1'b0;
        #1;
        chk("rst TXD", txd_w[0], 1'b1);
        chk("rst COUNT", cnt_w[0], 0);
        chk("rst OVF", ovf_w[0], 1'b0);
        chk("rst BUSY", busy_w[0], 1'b0);
        chk("rst C_READY", rdy_w[0], 1'b1);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        hbad = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge CLK); #1;
            if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0) hbad = 1'b1;
        end
        chk("rst line stays idle", hbad, 1'b0);
        $display("[TB] reset mid-frame done at edge %0d", cyc);

        // DIV=1 stream: a new character pushed on every start edge
        for (int q = 0; q < 4; q++) fbad[q] = 1'b0;
        cbad = 1'b0;
        c    = pk[0];
        v[2] = 1'b1;
        @(posedge CLK); #1;
        a = cyc;
        for (int n = 0; n <= 41; n++) begin
            if (n > 0) begin
                @(posedge CLK); #1;
            end
            if ((n % 10) == 0 && n < 30) begin
                c    = pk[n / 10 + 1];
                v[2] = 1'b1;
            end else begin
                v[2] = 1'b0;
            end
            if (n >= 1 && n <= 40) begin
                k = (n - 1) / 10;
                j = (n - 1) % 10;
                if (j == 0)      e = 1'b0;
                else if (j <= 7) e = pk_seq[k][7 - j];
                else if (j == 8) e = pk_par[k];
                else             e = 1'b1;
                if (txd_w[2] !== e) fbad[k] = 1'b1;
            end
            if (cnt_w[2] > 3'd1 || ovf_w[2] !== 1'b0) cbad = 1'b1;
        end
        for (int q = 0; q < 4; q++) begin
            chk($sformatf("stream frame %0d", q), fbad[q], 1'b0);
        end
        chk("stream count<=1 and no ovf", cbad, 1'b0);
        chk("stream idle TXD", txd_w[2], 1'b1);
        chk("stream idle BUSY", busy_w[2], 1'b0);
        $display("[TB] DIV=1 stream from edge %0d done", a);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
